// File: rtl/mul_share_if.sv
// Request/response and multiplier-side signals of the shared multiplier controller.
interface mul_share_if #(
  parameter int unsigned BITS = 16
);
  logic              req_valid_0;
  logic              req_ready_0;
  logic [BITS-1:0]   req_a_0;
  logic [BITS-1:0]   req_b_0;
  logic              req_sgn_0;
  logic              rsp_valid_0;
  logic              rsp_ready_0;
  logic [2*BITS-1:0] rsp_p_0;

  logic              req_valid_1;
  logic              req_ready_1;
  logic [BITS-1:0]   req_a_1;
  logic [BITS-1:0]   req_b_1;
  logic              req_sgn_1;
  logic              rsp_valid_1;
  logic              rsp_ready_1;
  logic [2*BITS-1:0] rsp_p_1;

  logic [BITS-1:0]   mul_a;
  logic [BITS-1:0]   mul_b;
  logic              mul_sgn;
  logic [2*BITS-1:0] mul_p;

  modport slave (
    input  req_valid_0, req_a_0, req_b_0, req_sgn_0, rsp_ready_0,
    input  req_valid_1, req_a_1, req_b_1, req_sgn_1, rsp_ready_1,
    input  mul_p,
    output req_ready_0, rsp_valid_0, rsp_p_0,
    output req_ready_1, rsp_valid_1, rsp_p_1,
    output mul_a, mul_b, mul_sgn
  );

  modport master (
    output req_valid_0, req_a_0, req_b_0, req_sgn_0, rsp_ready_0,
    output req_valid_1, req_a_1, req_b_1, req_sgn_1, rsp_ready_1,
    output mul_p,
    input  req_ready_0, rsp_valid_0, rsp_p_0,
    input  req_ready_1, rsp_valid_1, rsp_p_1,
    input  mul_a, mul_b, mul_sgn
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Two-port arbiter/sequencer for one shared multicycle combinational multiplier.
// MUL_SHARE_FIXED_PRIO_EN: port 0 always wins ties (default: round-robin).
module mul_share_ctrl #(
  parameter int unsigned BITS = 16,
  parameter int unsigned LAT  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_share_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              owner_q, owner_d;
  logic [BITS-1:0]   a_q, a_d;
  logic [BITS-1:0]   b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [2*BITS-1:0] result_q, result_d;
  logic              pick1;
  logic              accept;

`ifdef MUL_SHARE_FIXED_PRIO_EN
  always_comb begin
    pick1 = bus.req_valid_1 && !bus.req_valid_0;
  end
`else
  logic last_q, last_d;

  // last_q holds the index of the most recently granted port; reset to 1 so port 0 wins first.
  always_comb begin
    pick1 = bus.req_valid_1 && (!bus.req_valid_0 || !last_q);
  end

  always_comb begin
    last_d = last_q;
    if (accept) last_d = pick1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  always_comb begin
    accept = (state_q == IDLE) && (bus.req_valid_0 || bus.req_valid_1);
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = pick1;
          a_d     = pick1 ? bus.req_a_1   : bus.req_a_0;
          b_d     = pick1 ? bus.req_b_1   : bus.req_b_0;
          sgn_d   = pick1 ? bus.req_sgn_1 : bus.req_sgn_0;
          count_d = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (count_q == '0) begin
          result_d = bus.mul_p;
          state_d  = RESP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      RESP: begin
        if (owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
    end
  end

  assign bus.req_ready_0 = (state_q == IDLE) && bus.req_valid_0 && !pick1;
  assign bus.req_ready_1 = (state_q == IDLE) && pick1;
  assign bus.rsp_valid_0 = (state_q == RESP) && !owner_q;
  assign bus.rsp_valid_1 = (state_q == RESP) && owner_q;
  assign bus.rsp_p_0     = result_q;
  assign bus.rsp_p_1     = result_q;
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;
  assign bus.mul_sgn     = sgn_q;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Randomized bench for mul_share_ctrl against a transaction-level timing/arbitration model.
module tb_mul_share_ctrl;
  localparam int unsigned BITS = 16;
  localparam int unsigned LAT  = 2;
`ifdef MUL_SHARE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_share_if #(.BITS(BITS)) bus ();

  mul_share_ctrl #(.BITS(BITS), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return s ? 32'(sa * sb) : ({16'b0, a} * {16'b0, b});
  endfunction

  // Multiplier stand-in: output is garbage until its inputs have been stable long enough.
  logic [32:0] snap = '0;
  int settle = 0;
  always @(negedge clk) begin
    if ({bus.mul_sgn, bus.mul_a, bus.mul_b} != snap) begin
      snap   = {bus.mul_sgn, bus.mul_a, bus.mul_b};
      settle = 0;
    end else begin
      settle++;
    end
    bus.mul_p = prod(bus.mul_a, bus.mul_b, bus.mul_sgn) ^ ((settle >= int'(LAT) - 1) ? 32'h0 : 32'hA5A5_5A5A);
  end

  // Reference model: pending requests per port, one op in flight.
  bit          pend [2];
  logic [15:0] pa [2];
  logic [15:0] pb [2];
  logic        ps [2];
  int          last_g   = 1;
  bit          inflight = 0;
  int          k        = 0;
  int          own      = 0;
  logic [15:0] ea, eb;
  logic        es;

  task automatic post(input int p, input logic [15:0] a, input logic [15:0] b, input logic s);
    pend[p] = 1'b1; pa[p] = a; pb[p] = b; ps[p] = s;
  endtask

  task automatic cycle(input bit rdy0, input bit rdy1);
    int g;
    bit rv;
    bus.req_valid_0 = pend[0]; bus.req_a_0 = pa[0]; bus.req_b_0 = pb[0]; bus.req_sgn_0 = ps[0];
    bus.req_valid_1 = pend[1]; bus.req_a_1 = pa[1]; bus.req_b_1 = pb[1]; bus.req_sgn_1 = ps[1];
    bus.rsp_ready_0 = rdy0;
    bus.rsp_ready_1 = rdy1;
    #1;
    g = -1;
    if (!inflight) begin
      if (pend[0] && pend[1]) g = FIXED ? 0 : ((last_g == 1) ? 0 : 1);
      else if (pend[0])       g = 0;
      else if (pend[1])       g = 1;
    end
    rv = inflight && (k >= int'(LAT));
    check("req_ready_0", bus.req_ready_0, g == 0);
    check("req_ready_1", bus.req_ready_1, g == 1);
    check("rsp_valid_0", bus.rsp_valid_0, rv && own == 0);
    check("rsp_valid_1", bus.rsp_valid_1, rv && own == 1);
    if (rv) begin
      check("rsp_p_0", bus.rsp_p_0, prod(ea, eb, es));
      check("rsp_p_1", bus.rsp_p_1, prod(ea, eb, es));
    end
    if (inflight) begin
      check("mul_a", bus.mul_a, ea);
      check("mul_b", bus.mul_b, eb);
      check("mul_sgn", bus.mul_sgn, es);
    end
    @(posedge clk);
    if (inflight) begin
      if (rv && ((own == 0) ? rdy0 : rdy1)) inflight = 0;
      else k++;
    end else if (g >= 0) begin
      inflight = 1; k = 0; own = g; last_g = g;
      ea = pa[g]; eb = pb[g]; es = ps[g]; pend[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    inflight = 0; k = 0; last_g = 1;
  endtask

  initial begin
    model_reset();
    for (int p = 0; p < 2; p++) begin pa[p] = '0; pb[p] = '0; ps[p] = 1'b0; end
    bus.req_valid_0 = 0; bus.req_a_0 = '0; bus.req_b_0 = '0; bus.req_sgn_0 = 0; bus.rsp_ready_0 = 0;
    bus.req_valid_1 = 0; bus.req_a_1 = '0; bus.req_b_1 = '0; bus.req_sgn_1 = 0; bus.rsp_ready_1 = 0;
    repeat (3) @(negedge clk);
    check("rst_mul_a", bus.mul_a, 16'h0);
    check("rst_mul_b", bus.mul_b, 16'h0);
    check("rst_mul_sgn", bus.mul_sgn, 1'b0);
    check("rst_rsp_p_0", bus.rsp_p_0, 32'h0);
    check("rst_rsp_valid", {bus.rsp_valid_0, bus.rsp_valid_1}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Single op on port 0: 3*5
    post(0, 16'd3, 16'd5, 1'b0);
    repeat (6) cycle(1'b1, 1'b1);

    // Simultaneous requests
    post(0, 16'd7, 16'd9, 1'b0);
    post(1, 16'hFFFF, 16'hFFFF, 1'b0);
    repeat (12) cycle(1'b1, 1'b1);

    // Port 1 back-to-back with port 0 idle
    for (int i = 0; i < 4; i++) begin
      post(1, 16'($urandom), 16'($urandom), 1'($urandom));
      repeat (5) cycle(1'b1, 1'b1);
    end

    // Backpressure on port 0 with port 1 waiting
    post(0, 16'h1234, 16'h5678, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    post(1, 16'h00FF, 16'h0101, 1'b0);
    repeat (5) cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b1);

    // Signed corner
    post(0, 16'hFFFF, 16'h0002, 1'b1);
    repeat (6) cycle(1'b1, 1'b1);

    // Asynchronous reset during BUSY
    post(0, 16'h0ABC, 16'h0DEF, 1'b0);
    repeat (2) cycle(1'b1, 1'b1);
    pend[0] = 1'b0;
    bus.req_valid_0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", {bus.rsp_valid_0, bus.rsp_valid_1}, 2'b00);
    check("arst_mul_a", bus.mul_a, 16'h0);
    check("arst_mul_b", bus.mul_b, 16'h0);
    check("arst_rsp_p", bus.rsp_p_0, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) cycle(1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       post(p, 16'hFFFF, 16'($urandom), 1'($urandom));
            1:       post(p, 16'h8000, 16'h8000, 1'($urandom));
            default: post(p, 16'($urandom), 16'($urandom), 1'($urandom));
          endcase
        end
      end
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end
    repeat (20) cycle(1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
